// File: rtl/tl_rx_pkg.sv
// Purpose: shared buffer-type codes, bus slice indices, UpdateFC encoding and arbiter helper for the RX FC path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package tl_rx_pkg;

  localparam int NUM_TYPES = 3;

  // Buffer type codes as presented by the write and read handlers (2'b11 is unused)
  localparam logic [1:0] BT_P   = 2'd0;
  localparam logic [1:0] BT_NP  = 2'd1;
  localparam logic [1:0] BT_CPL = 2'd2;

  // Slot index of each type inside the packed counter buses; bit offset = slot * field width
  localparam int SLICE_P   = 0;
  localparam int SLICE_NP  = 1;
  localparam int SLICE_CPL = 2;

  // UpdateFC type code handed to DLL-TX
  localparam logic [1:0] UFC_TYPE_P   = 2'b00;
  localparam logic [1:0] UFC_TYPE_NP  = 2'b01;
  localparam logic [1:0] UFC_TYPE_CPL = 2'b10;

  typedef enum logic {
    UFC_IDLE = 1'b0,
    UFC_REQ  = 1'b1
  } ufc_state_e;

  function automatic logic [1:0] ufc_type_of(input logic [1:0] bt);
    case (bt)
      BT_P:    ufc_type_of = UFC_TYPE_P;
      BT_NP:   ufc_type_of = UFC_TYPE_NP;
      default: ufc_type_of = UFC_TYPE_CPL;
    endcase
  endfunction

  // Round-robin pick: first pending type strictly after 'last', wrapping through all three.
  // Scanning from the farthest candidate down lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [2:0] pend, input logic [1:0] last);
    logic [2:0] cand;
    rr_pick = last;
    for (int k = 3; k >= 1; k--) begin
      cand = {1'b0, last} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (pend[cand[1:0]]) rr_pick = cand[1:0];
    end
  endfunction

endpackage

// File: rtl/tl_rx_fc_type_counter.sv
// Purpose: one buffer type's received/allocated hdr+data credit counters and its UpdateFC pending flag.
// Latency: counters and pending flag update on the clock edge that samples the increment/release.
// Backpressure: none; every increment and release is absorbed, counters wrap modulo their width.
module tl_rx_fc_type_counter #(
  parameter int HDR_W     = 8,
  parameter int DATA_W    = 12,
  parameter int HDR_INIT  = 32,
  parameter int DATA_INIT = 256
) (
  input  logic              i_clk,
  input  logic              i_n_rst,
  input  logic              i_hdr_inc,
  input  logic              i_data_inc,
  input  logic [DATA_W-1:0] i_data_creds,
  input  logic              i_rel_valid,
  input  logic [DATA_W-1:0] i_rel_data_creds,
  input  logic              i_timer_wrap,
  input  logic              i_pend_clr,
  output logic [HDR_W-1:0]  o_hdr_received,
  output logic [DATA_W-1:0] o_data_received,
  output logic [HDR_W-1:0]  o_hdr_alloc,
  output logic [DATA_W-1:0] o_data_alloc,
  output logic              o_pending
);

  // An INIT of 0 advertises infinite credits: that field never moves
  localparam logic HDR_FIN  = (HDR_INIT != 0);
  localparam logic DATA_FIN = (DATA_INIT != 0);
  localparam logic TYPE_FIN = HDR_FIN | DATA_FIN;

  localparam logic [HDR_W-1:0]  HDR_RST  = HDR_W'(HDR_INIT);
  localparam logic [DATA_W-1:0] DATA_RST = DATA_W'(DATA_INIT);
  localparam logic [HDR_W-1:0]  HDR_ONE  = HDR_W'(1);

  logic [HDR_W-1:0]  hdr_rcv_q, hdr_rcv_d;
  logic [DATA_W-1:0] data_rcv_q, data_rcv_d;
  logic [HDR_W-1:0]  hdr_alc_q, hdr_alc_d;
  logic [DATA_W-1:0] data_alc_q, data_alc_d;
  logic              pend_q, pend_d;

  // Next-state: consume and release apply together; a set beats the grant clear so no release is lost
  always_comb begin
    hdr_rcv_d  = hdr_rcv_q;
    data_rcv_d = data_rcv_q;
    hdr_alc_d  = hdr_alc_q;
    data_alc_d = data_alc_q;
    pend_d     = pend_q;
    if (HDR_FIN) begin
      if (i_hdr_inc)   hdr_rcv_d = hdr_rcv_q + HDR_ONE;
      if (i_rel_valid) hdr_alc_d = hdr_alc_q + HDR_ONE;
    end
    if (DATA_FIN) begin
      if (i_data_inc)  data_rcv_d = data_rcv_q + i_data_creds;
      if (i_rel_valid) data_alc_d = data_alc_q + i_rel_data_creds;
    end
    if (i_pend_clr) pend_d = 1'b0;
    if (TYPE_FIN && (i_rel_valid || i_timer_wrap)) pend_d = 1'b1;
  end

  // Counter and pending registers
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      hdr_rcv_q  <= '0;
      data_rcv_q <= '0;
      hdr_alc_q  <= HDR_RST;
      data_alc_q <= DATA_RST;
      pend_q     <= 1'b0;
    end else begin
      hdr_rcv_q  <= hdr_rcv_d;
      data_rcv_q <= data_rcv_d;
      hdr_alc_q  <= hdr_alc_d;
      data_alc_q <= data_alc_d;
      pend_q     <= pend_d;
    end
  end

  assign o_hdr_received  = hdr_rcv_q;
  assign o_data_received = data_rcv_q;
  assign o_hdr_alloc     = hdr_alc_q;
  assign o_data_alloc    = data_alc_q;
  assign o_pending       = pend_q;

endmodule

// File: rtl/tl_rx_fc_credit_tracker.sv
// Purpose: VC0 RX flow-control credit bookkeeping plus UpdateFC scheduling toward DLL-TX.
// Latency: counter buses reflect an increment/release 1 cycle later; UpdateFC req rises 1 cycle after pending is seen.
// Backpressure: UpdateFC req and its payload hold until i_updatefc_ack; further requests wait as pending flags.
module tl_rx_fc_credit_tracker
  import tl_rx_pkg::*;
#(
  parameter int HDR_FIELD_SIZE  = 8,
  parameter int DATA_FIELD_SIZE = 12,
  parameter int PAYLOAD_LENGTH  = 10,
  parameter int TYPE_DEC_WIDTH  = 2,
  parameter int P_HDR_INIT      = 32,
  parameter int NP_HDR_INIT     = 32,
  parameter int CPL_HDR_INIT    = 0,
  parameter int P_DATA_INIT     = 256,
  parameter int NP_DATA_INIT    = 32,
  parameter int CPL_DATA_INIT   = 0,
  parameter int UPDATEFC_PERIOD = 7500
) (
  input  logic                         i_clk,
  input  logic                         i_n_rst,
  input  logic                         i_cr_hdr_inc,
  input  logic                         i_cr_data_inc,
  input  logic [PAYLOAD_LENGTH-1:0]    i_payload_length,
  input  logic [TYPE_DEC_WIDTH-1:0]    i_buffer_type,
  input  logic                         i_rd_release_valid,
  input  logic [TYPE_DEC_WIDTH-1:0]    i_rd_release_type,
  input  logic [8:0]                   i_rd_release_data_creds,
  output logic [3*HDR_FIELD_SIZE-1:0]  o_rx_fc_hdr_credits_received_bus,
  output logic [3*DATA_FIELD_SIZE-1:0] o_rx_fc_data_credits_received_bus,
  output logic [3*HDR_FIELD_SIZE-1:0]  o_rx_fc_hdr_credits_allocated_bus,
  output logic [3*DATA_FIELD_SIZE-1:0] o_rx_fc_data_credits_allocated_bus,
  output logic                         o_updatefc_req,
  output logic [1:0]                   o_updatefc_type,
  output logic [HDR_FIELD_SIZE-1:0]    o_updatefc_hdr_creds,
  output logic [DATA_FIELD_SIZE-1:0]   o_updatefc_data_creds,
  input  logic                         i_updatefc_ack
);

  localparam int LW = PAYLOAD_LENGTH + 1;
  localparam int TW = (UPDATEFC_PERIOD > 2) ? $clog2(UPDATEFC_PERIOD) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(UPDATEFC_PERIOD - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic [LW-1:0]              len_dw;
  logic [LW-1:0]              len_sum;
  logic [DATA_FIELD_SIZE-1:0] cons_creds;
  logic [DATA_FIELD_SIZE-1:0] rel_creds;

  logic [HDR_FIELD_SIZE-1:0]  hdr_rcv  [NUM_TYPES];
  logic [DATA_FIELD_SIZE-1:0] data_rcv [NUM_TYPES];
  logic [HDR_FIELD_SIZE-1:0]  hdr_alc  [NUM_TYPES];
  logic [DATA_FIELD_SIZE-1:0] data_alc [NUM_TYPES];
  logic [2:0]                 pend_vec;
  logic [2:0]                 pend_clr;
  logic [1:0]                 pick;

  logic [TW-1:0]              timer_q;
  logic                       timer_wrap;

  ufc_state_e                 state_q;
  logic [1:0]                 last_q;
  logic                       req_q;
  logic [1:0]                 type_q;
  logic [HDR_FIELD_SIZE-1:0]  hdr_q;
  logic [DATA_FIELD_SIZE-1:0] data_q;

  // Payload DW to data credits: ceil(len/4), with a zero length field meaning 1024 DW
  always_comb begin
    len_dw     = (i_payload_length == '0) ? {1'b1, {PAYLOAD_LENGTH{1'b0}}} : {1'b0, i_payload_length};
    len_sum    = len_dw + LW'(3);
    cons_creds = DATA_FIELD_SIZE'(len_sum >> 2);
    rel_creds  = DATA_FIELD_SIZE'(i_rd_release_data_creds);
  end

  for (genvar t = 0; t < NUM_TYPES; t++) begin : g_type
    localparam int HINIT = (t == SLICE_P) ? P_HDR_INIT  : (t == SLICE_NP) ? NP_HDR_INIT  : CPL_HDR_INIT;
    localparam int DINIT = (t == SLICE_P) ? P_DATA_INIT : (t == SLICE_NP) ? NP_DATA_INIT : CPL_DATA_INIT;

    tl_rx_fc_type_counter #(
      .HDR_W     (HDR_FIELD_SIZE),
      .DATA_W    (DATA_FIELD_SIZE),
      .HDR_INIT  (HINIT),
      .DATA_INIT (DINIT)
    ) u_cnt (
      .i_clk            (i_clk),
      .i_n_rst          (i_n_rst),
      .i_hdr_inc        (i_cr_hdr_inc  && (i_buffer_type == TYPE_DEC_WIDTH'(t))),
      .i_data_inc       (i_cr_data_inc && (i_buffer_type == TYPE_DEC_WIDTH'(t))),
      .i_data_creds     (cons_creds),
      .i_rel_valid      (i_rd_release_valid && (i_rd_release_type == TYPE_DEC_WIDTH'(t))),
      .i_rel_data_creds (rel_creds),
      .i_timer_wrap     (timer_wrap),
      .i_pend_clr       (pend_clr[t]),
      .o_hdr_received   (hdr_rcv[t]),
      .o_data_received  (data_rcv[t]),
      .o_hdr_alloc      (hdr_alc[t]),
      .o_data_alloc     (data_alc[t]),
      .o_pending        (pend_vec[t])
    );

    // Slot t of every bus carries type t (P lowest, CPL highest)
    assign o_rx_fc_hdr_credits_received_bus [t*HDR_FIELD_SIZE  +: HDR_FIELD_SIZE]  = hdr_rcv[t];
    assign o_rx_fc_data_credits_received_bus[t*DATA_FIELD_SIZE +: DATA_FIELD_SIZE] = data_rcv[t];
    assign o_rx_fc_hdr_credits_allocated_bus[t*HDR_FIELD_SIZE  +: HDR_FIELD_SIZE]  = hdr_alc[t];
    assign o_rx_fc_data_credits_allocated_bus[t*DATA_FIELD_SIZE +: DATA_FIELD_SIZE] = data_alc[t];
  end

  // Grant selection; the served type's pending flag is cleared on the grant edge
  always_comb begin
    pick     = rr_pick(pend_vec, last_q);
    pend_clr = 3'b000;
    if ((state_q == UFC_IDLE) && (|pend_vec)) pend_clr[pick] = 1'b1;
  end

  assign timer_wrap = (timer_q == TMR_LAST);

  // Free-running refresh timer, 0..UPDATEFC_PERIOD-1
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst)        timer_q <= '0;
    else if (timer_wrap) timer_q <= '0;
    else                 timer_q <= timer_q + TMR_ONE;
  end

  // UpdateFC handshake: latch type and current allocated credits, hold until DLL-TX acks
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state_q <= UFC_IDLE;
      last_q  <= BT_CPL;
      req_q   <= 1'b0;
      type_q  <= '0;
      hdr_q   <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        UFC_IDLE: begin
          if (|pend_vec) begin
            req_q   <= 1'b1;
            type_q  <= ufc_type_of(pick);
            hdr_q   <= hdr_alc[pick];
            data_q  <= data_alc[pick];
            last_q  <= pick;
            state_q <= UFC_REQ;
          end
        end
        UFC_REQ: begin
          if (i_updatefc_ack) begin
            req_q   <= 1'b0;
            state_q <= UFC_IDLE;
          end
        end
        default: state_q <= UFC_IDLE;
      endcase
    end
  end

  assign o_updatefc_req        = req_q;
  assign o_updatefc_type       = type_q;
  assign o_updatefc_hdr_creds  = hdr_q;
  assign o_updatefc_data_creds = data_q;

endmodule

// File: doc/tl_rx_fc_credit_tracker.md
Name: tl_rx_fc_credit_tracker

Overview:
- RX flow-control credit bookkeeping for VC0, directly downstream of the RX write handler.
- Counts credits consumed by TLPs the write handler stores (CREDITS_RECEIVED) and credits returned when the read handler drains the RX buffers (CREDITS_ALLOCATED).
- Drives both counter sets back to the write handler's overflow check.
- Schedules UpdateFC DLLP requests toward DLL-TX.

Parameters:
HDR_FIELD_SIZE, 8, header credit counter width (modulo 2^8)
DATA_FIELD_SIZE, 12, data credit counter width (modulo 2^12)
PAYLOAD_LENGTH, 10, TLP length field width in DW
TYPE_DEC_WIDTH, 2, buffer type code width
P_HDR_INIT / NP_HDR_INIT / CPL_HDR_INIT, 32 / 32 / 0, advertised header credits (0 = infinite)
P_DATA_INIT / NP_DATA_INIT / CPL_DATA_INIT, 256 / 32 / 0, advertised data credits (0 = infinite)
UPDATEFC_PERIOD, 7500, cycles between periodic UpdateFC refreshes (minimum 2)

Ports:
i_clk  in  1  clock
i_n_rst  in  1  asynchronous active-low reset
i_cr_hdr_inc  in  1  write handler stored one header
i_cr_data_inc  in  1  write handler stored payload
i_payload_length  in  PAYLOAD_LENGTH  length in DW; 0 means 1024
i_buffer_type  in  TYPE_DEC_WIDTH  00 posted, 01 non-posted, 10 completion
i_rd_release_valid  in  1  read handler freed one TLP
i_rd_release_type  in  TYPE_DEC_WIDTH  type of the freed TLP
i_rd_release_data_creds  in  9  data credits freed (0..256)
o_rx_fc_hdr_credits_received_bus  out  3*HDR_FIELD_SIZE  packed P, NP, CPL
o_rx_fc_data_credits_received_bus  out  3*DATA_FIELD_SIZE  packed P, NP, CPL
o_rx_fc_hdr_credits_allocated_bus  out  3*HDR_FIELD_SIZE  packed P, NP, CPL
o_rx_fc_data_credits_allocated_bus  out  3*DATA_FIELD_SIZE  packed P, NP, CPL
o_updatefc_req  out  1  UpdateFC request
o_updatefc_type  out  2  type of the requested UpdateFC
o_updatefc_hdr_creds  out  HDR_FIELD_SIZE  header credits to advertise
o_updatefc_data_creds  out  DATA_FIELD_SIZE  data credits to advertise
i_updatefc_ack  in  1  DLL-TX accepted the request

Behaviour:
- Clock and reset: single clock i_clk; reset i_n_rst is asynchronous, active-low.
- Reset values:
  - received counters = 0.
  - allocated counters = their INIT values.
  - pending flags = 0; timer = 0.
  - o_updatefc_req = 0; type and credit outputs = 0.
- Bus packing: bits [F-1:0] = P, [2F-1:F] = NP, [3F-1:2F] = CPL.
- Consume (registered, 1-cycle latency to buses):
  - i_cr_hdr_inc: hdr_received[i_buffer_type] += 1.
  - i_cr_data_inc: data_received[i_buffer_type] += ceil(len/4), with len=0 treated as 1024, giving 256.
  - Both may assert in the same cycle.
  - Type code 11: ignored.
- Release:
  - i_rd_release_valid: hdr_alloc[type] += 1; data_alloc[type] += i_rd_release_data_creds.
  - Sets pending[type].
- Width and counter rules:
  - All sums wrap modulo field width; there is no saturation.
  - Consume and release on the same type in the same cycle both apply.
  - Infinite types (INIT 0): counters are frozen at 0 and pending is never set.
- Timer:
  - Counts 0..UPDATEFC_PERIOD-1.
  - On wrap, sets pending for every finite type.
  - A timer wrap coinciding with a release ORs the flags.
- UpdateFC FSM states:
  - IDLE: if any pending flag is set, pick round-robin starting after the last-served type. Latch type and the current alloc values, assert req, and clear that pending flag. Go to REQ.
  - REQ: hold req and the latched outputs stable until i_updatefc_ack, then deassert req the next cycle and return to IDLE.
  - Ack is sampled only in REQ.
  - A release of the latched type while in REQ sets pending again; a fresh UpdateFC follows later.
- Ordering: the first grant after reset scans from P.
- Reset mid-request: req drops asynchronously; all state returns to reset values.

Decomposition:
- Shared package (tl_rx_pkg):
  - Buffer type codes (P=0, NP=1, CPL=2).
  - Bus slice offset constants.
  - UpdateFC type encoding.
- Natural sub-module: tl_rx_fc_type_counter, instantiated 3×. It holds one type's hdr/data received and allocated counters plus the pending set logic.
- The top level holds the timer, round-robin arbiter and FSM.

Test Plan:
- Reset release → received buses 0; alloc bus P = hdr 32, data 256; req = 0.
- hdr_inc + data_inc, posted, length 5 → next cycle P hdr_received = 1, P data_received = 2; NP and CPL unchanged.
- Length 0 on NP data_inc ×16 → NP data_received = 4096 mod 4096 = 0, demonstrating wrap.
- Release NP with 3 data credits → req with type = NP, hdr = 33, data = 35. Outputs hold until ack is held off for 10 cycles; req drops 1 cycle after ack.
- Release P and NP in consecutive cycles → two requests in order P then NP. A P release during the P request → a third request for P.
- UPDATEFC_PERIOD = 16, no traffic → P and NP requests each 16 cycles; no CPL request because CPL is infinite.
